param_regfile: RTL and testbench

Parametrised, multi-type control/status register file for block configuration, status and interrupt reporting. It generalises the fixed 32-bit, six-register design to configurable data width, register count and per-register access type. It adds registered read responses, write responses with error reporting, hardware-set status bits and an interrupt output. It sits between the host bus adapter and the block datapath.

---
 rtl/param_regfile.sv | 168 ++++++++++++++++
 tb/tb_param_regfile.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/param_regfile.sv
// Parametrised CSR file: RW / RO / W1C / WO registers, registered read/write responses and irq.
// Define PARAM_REGFILE_IRQ_MASK_EN to add an RW irq-mask register at index NUM_REGS.
module param_regfile #(
  parameter int                             DATA_WIDTH  = 32,
  parameter int                             ADDR_WIDTH  = 8,
  parameter int                             NUM_REGS    = 8,
  parameter logic [NUM_REGS-1:0]            RO_MASK     = '0,
  parameter logic [NUM_REGS-1:0]            W1C_MASK    = '0,
  parameter logic [NUM_REGS-1:0]            WO_MASK     = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_valid,
  input  logic [ADDR_WIDTH-1:0]          wr_addr,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  input  logic [DATA_WIDTH/8-1:0]        wr_be,
  output logic                           wr_resp_valid,
  output logic                           wr_err,
  input  logic                           rd_valid,
  input  logic [ADDR_WIDTH-1:0]          rd_addr,
  output logic                           rd_resp_valid,
  output logic [DATA_WIDTH-1:0]          rd_data,
  output logic                           rd_err,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_val,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_set,
  output logic                           irq,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out
);
  localparam int NB  = DATA_WIDTH / 8;
  localparam int LSB = $clog2(NB);
`ifdef PARAM_REGFILE_IRQ_MASK_EN
  localparam int NUM_IDX = NUM_REGS + 1;
`else
  localparam int NUM_IDX = NUM_REGS;
`endif
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(NB - 1);

  // Effective register type once the RO > W1C > WO > RW precedence is applied.
  localparam logic [NUM_REGS-1:0] IS_RO  = RO_MASK;
  localparam logic [NUM_REGS-1:0] IS_W1C = W1C_MASK & ~RO_MASK;
  localparam logic [NUM_REGS-1:0] IS_WO  = WO_MASK & ~W1C_MASK & ~RO_MASK;

  typedef logic [DATA_WIDTH-1:0] word_t;

  word_t               regs_q [NUM_REGS];
  word_t               regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] wo_done_q, wo_done_d;
  logic [NUM_REGS-1:0] wr_sel;
  logic [ADDR_WIDTH-1:0] wr_idx, rd_idx;
  logic                wr_ok, rd_ok;
  logic                wr_err_d, irq_d;
  word_t               be_mask, rd_word;
`ifdef PARAM_REGFILE_IRQ_MASK_EN
  word_t               irq_mask_q, irq_mask_d;
`endif

  // Hardware inputs are only consumed for registers of the matching type.
  logic unused_hw;
  assign unused_hw = ^{hw_val, hw_set};

  assign wr_idx = wr_addr >> LSB;
  assign rd_idx = rd_addr >> LSB;
  assign wr_ok  = ((wr_addr & ALIGN_MASK) == '0) && (32'(wr_idx) < NUM_IDX);
  assign rd_ok  = ((rd_addr & ALIGN_MASK) == '0) && (32'(rd_idx) < NUM_IDX);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    be_mask = '0;
    for (int b = 0; b < NB; b++) be_mask[b*8 +: 8] = {8{wr_be[b]}};
  end

  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NUM_REGS; i++)
      wr_sel[i] = wr_valid && wr_ok && (wr_idx == ADDR_WIDTH'(i));
  end

  always_comb begin
    wo_done_d = wo_done_q;
    wr_err_d  = !wr_ok;
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (IS_RO[i]) begin
        regs_d[i] = hw_val[i*DATA_WIDTH +: DATA_WIDTH];
        if (wr_sel[i] && (|wr_be)) wr_err_d = 1'b1;
      end else if (IS_W1C[i]) begin
        // Set is OR-ed in after the clear so a simultaneous set wins.
        regs_d[i] = (regs_q[i] & ~(wr_sel[i] ? (wr_data & be_mask) : '0))
                  | hw_set[i*DATA_WIDTH +: DATA_WIDTH];
      end else if (IS_WO[i]) begin
        if (wr_sel[i] && (|wr_be)) begin
          if (wo_done_q[i]) begin
            wr_err_d = 1'b1;
          end else begin
            regs_d[i]    = (regs_q[i] & ~be_mask) | (wr_data & be_mask);
            wo_done_d[i] = 1'b1;
          end
        end
      end else if (wr_sel[i]) begin
        regs_d[i] = (regs_q[i] & ~be_mask) | (wr_data & be_mask);
      end
    end
  end

`ifdef PARAM_REGFILE_IRQ_MASK_EN
  always_comb begin
    irq_mask_d = irq_mask_q;
    if (wr_valid && wr_ok && (wr_idx == ADDR_WIDTH'(NUM_REGS)))
      irq_mask_d = (irq_mask_q & ~be_mask) | (wr_data & be_mask);
  end
`endif

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (rd_idx == ADDR_WIDTH'(i)) rd_word = regs_q[i];
`ifdef PARAM_REGFILE_IRQ_MASK_EN
    if (rd_idx == ADDR_WIDTH'(NUM_REGS)) rd_word = irq_mask_q;
`endif
  end

  always_comb begin
    irq_d = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
`ifdef PARAM_REGFILE_IRQ_MASK_EN
      if (IS_W1C[i] && (|(regs_q[i] & irq_mask_q))) irq_d = 1'b1;
`else
      if (IS_W1C[i] && (|regs_q[i])) irq_d = 1'b1;
`endif
    end
  end

  always_comb begin
    regs_out = '0;
    for (int i = 0; i < NUM_REGS; i++) regs_out[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
  end

  // NOTE: state is written with non-blocking assignments only; all next-state math stays combinational.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the register array is flop storage, not a RAM, so each entry is reset explicitly.
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VALUE[i*DATA_WIDTH +: DATA_WIDTH];
      wo_done_q     <= '0;
      wr_resp_valid <= 1'b0;
      wr_err        <= 1'b0;
      rd_resp_valid <= 1'b0;
      rd_data       <= '0;
      rd_err        <= 1'b0;
      irq           <= 1'b0;
`ifdef PARAM_REGFILE_IRQ_MASK_EN
      irq_mask_q    <= '0;
`endif
    end else begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
      wo_done_q     <= wo_done_d;
      wr_resp_valid <= wr_valid;
      wr_err        <= wr_valid && wr_err_d;
      rd_resp_valid <= rd_valid;
      rd_data       <= (rd_valid && rd_ok) ? rd_word : '0;
      rd_err        <= rd_valid && !rd_ok;
      irq           <= irq_d;
`ifdef PARAM_REGFILE_IRQ_MASK_EN
      irq_mask_q    <= irq_mask_d;
`endif
    end
  end
endmodule

// File: tb/tb_param_regfile.sv
// Self-checking bench for param_regfile (default build): directed steps, then random traffic
// checked against a behavioural model of the register map.
`timescale 1ns/1ps
module tb_param_regfile;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int NR = 8;
  localparam int NB = DW / 8;
  localparam logic [NR-1:0] RO_M  = 8'b1001_0000;
  localparam logic [NR-1:0] W1C_M = 8'b1100_0100;
  localparam logic [NR-1:0] WO_M  = 8'b0100_1000;
  localparam logic [NR*DW-1:0] RST_V = {32'h0000_0011, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_00A5,
                                        32'h0000_0000, 32'h0000_0000, 32'h0001_0000, 32'h0000_0000};

  logic clk, rst;
  logic wr_valid, wr_resp_valid, wr_err;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data, rd_data;
  logic [NB-1:0] wr_be;
  logic rd_valid, rd_resp_valid, rd_err, irq;
  logic [NR*DW-1:0] hw_val, hw_set, regs_out;

  param_regfile #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR),
    .RO_MASK(RO_M), .W1C_MASK(W1C_M), .WO_MASK(WO_M), .RESET_VALUE(RST_V)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .wr_resp_valid(wr_resp_valid), .wr_err(wr_err),
    .rd_valid(rd_valid), .rd_addr(rd_addr),
    .rd_resp_valid(rd_resp_valid), .rd_data(rd_data), .rd_err(rd_err),
    .hw_val(hw_val), .hw_set(hw_set), .irq(irq), .regs_out(regs_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum {K_RW, K_RO, K_W1C, K_WO} kind_e;

  logic [DW-1:0] m_regs [NR];
  logic [NR-1:0] m_wo;
  int total = 0;
  int bad   = 0;

  function automatic kind_e kind_of(int i);
    if (RO_M[i])  return K_RO;
    if (W1C_M[i]) return K_W1C;
    if (WO_M[i])  return K_WO;
    return K_RW;
  endfunction

  function automatic logic [DW-1:0] rst_val(int i);
    return RST_V[i*DW +: DW];
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: predict from the model, clock the DUT, compare, then advance the model.
  task automatic step();
    logic [DW-1:0] nxt [NR];
    logic [NR-1:0] nwo;
    logic [DW-1:0] bmask, clr, e_rd;
    logic e_wv, e_we, e_rv, e_re, e_irq, was_rst;
    int widx, ridx;
    bit wok, rok;
    for (int b = 0; b < NB; b++) bmask[b*8 +: 8] = wr_be[b] ? 8'hFF : 8'h00;
    widx = int'(wr_addr) / NB;
    ridx = int'(rd_addr) / NB;
    wok  = (int'(wr_addr) % NB == 0) && (widx < NR);
    rok  = (int'(rd_addr) % NB == 0) && (ridx < NR);
    was_rst = rst;
    nwo  = m_wo;
    e_we = 1'b0; e_re = 1'b0; e_rd = '0; e_irq = 1'b0;
    e_wv = 1'b0; e_rv = 1'b0;
    if (rst) begin
      for (int i = 0; i < NR; i++) nxt[i] = rst_val(i);
      nwo = '0;
    end else begin
      e_wv = wr_valid;
      e_rv = rd_valid;
      for (int i = 0; i < NR; i++) begin
        nxt[i] = m_regs[i];
        if (kind_of(i) == K_W1C && m_regs[i] != '0) e_irq = 1'b1;
      end
      if (rd_valid) begin
        e_re = !rok;
        if (rok) e_rd = m_regs[ridx];
      end
      if (wr_valid) begin
        if (!wok) e_we = 1'b1;
        else if (wr_be != '0) begin
          case (kind_of(widx))
            K_RO:  e_we = 1'b1;
            K_WO:  if (m_wo[widx]) e_we = 1'b1;
                   else begin
                     nxt[widx] = (m_regs[widx] & ~bmask) | (wr_data & bmask);
                     nwo[widx] = 1'b1;
                   end
            K_RW:  nxt[widx] = (m_regs[widx] & ~bmask) | (wr_data & bmask);
            default: ;
          endcase
        end
      end
      for (int i = 0; i < NR; i++) begin
        if (kind_of(i) == K_RO) nxt[i] = hw_val[i*DW +: DW];
        if (kind_of(i) == K_W1C) begin
          clr = (wr_valid && wok && widx == i) ? (wr_data & bmask) : '0;
          nxt[i] = (m_regs[i] & ~clr) | hw_set[i*DW +: DW];
        end
      end
    end
    @(posedge clk);
    #1;
    check("wr_resp_valid", DW'(wr_resp_valid), DW'(e_wv));
    if (e_wv || was_rst) check("wr_err", DW'(wr_err), DW'(e_we));
    check("rd_resp_valid", DW'(rd_resp_valid), DW'(e_rv));
    if (e_rv || was_rst) begin
      check("rd_err", DW'(rd_err), DW'(e_re));
      check("rd_data", rd_data, e_rd);
    end
    check("irq", DW'(irq), DW'(e_irq));
    for (int i = 0; i < NR; i++) check($sformatf("regs_out[%0d]", i), regs_out[i*DW +: DW], nxt[i]);
    for (int i = 0; i < NR; i++) m_regs[i] = nxt[i];
    m_wo = nwo;
  endtask

  task automatic idle();
    wr_valid = 1'b0; rd_valid = 1'b0; hw_set = '0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] be);
    wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
  endtask

  task automatic rd(input logic [AW-1:0] a);
    rd_valid = 1'b1; rd_addr = a;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    int v;
    if ($urandom_range(0, 7) == 0) v = int'($urandom_range(0, 39));
    else v = int'($urandom_range(0, NR)) * NB;
    return AW'(v);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wr_addr = '0; wr_data = '0; wr_be = '0; rd_addr = '0;
    hw_val = RST_V;
    idle();
    step(); step();
    rst = 1'b0;
    check("rst_reg1", regs_out[1*DW +: DW], 32'h0001_0000);

    // Reset contents of every index, plus the out-of-range index.
    for (int i = 0; i <= NR; i++) begin
      rd(AW'(i * NB));
      step();
      if (i < NR) check($sformatf("rst_read[%0d]", i), rd_data, rst_val(i));
      else begin
        check("oob_rd_err", DW'(rd_err), 32'd1);
        check("oob_rd_data", rd_data, 32'd0);
      end
    end

    // RW partial write.
    idle(); wr(8'h00, 32'hAABB_CCDD, 4'b0101); step();
    check("rw_wr_err", DW'(wr_err), 32'd0);
    idle(); rd(8'h00); step();
    check("rw_partial", rd_data, 32'h00BB_00DD);

    // W1C set, set-wins-over-clear, clear, irq latency.
    idle(); hw_set[2*DW + 3] = 1'b1; step();
    check("irq_one_cycle", DW'(irq), 32'd0);
    idle(); step();
    check("irq_two_cycles", DW'(irq), 32'd1);
    idle(); hw_set[2*DW + 3] = 1'b1; wr(8'h08, 32'h8, 4'hF); step();
    check("w1c_set_wins", regs_out[2*DW +: DW], 32'h8);
    idle(); wr(8'h08, 32'h8, 4'hF); step();
    check("w1c_cleared", regs_out[2*DW +: DW], 32'h0);
    check("irq_still_high", DW'(irq), 32'd1);
    idle(); step();
    check("irq_fall", DW'(irq), 32'd0);

    // WO: empty write does not consume, first write sticks, second errors, reset re-arms.
    idle(); wr(8'h0C, 32'hFFFF_FFFF, 4'h0); step();
    check("wo_be0_err", DW'(wr_err), 32'd0);
    idle(); wr(8'h0C, 32'h1234_5678, 4'hF); step();
    check("wo_first_err", DW'(wr_err), 32'd0);
    idle(); wr(8'h0C, 32'hFFFF_FFFF, 4'hF); step();
    check("wo_second_err", DW'(wr_err), 32'd1);
    idle(); rd(8'h0C); step();
    check("wo_value", rd_data, 32'h1234_5678);
    idle(); rst = 1'b1; step(); rst = 1'b0;
    wr(8'h0C, 32'h0BAD_F00D, 4'hF); step();
    check("wo_rearm_err", DW'(wr_err), 32'd0);
    check("wo_rearm_val", regs_out[3*DW +: DW], 32'h0BAD_F00D);

    // RO capture and error writes.
    idle(); hw_val[4*DW +: DW] = 32'hCAFE_0001; step();
    idle(); rd(8'h10); step();
    check("ro_capture", rd_data, 32'hCAFE_0001);
    idle(); wr(8'h10, 32'h5555_5555, 4'hF); step();
    check("ro_wr_err", DW'(wr_err), 32'd1);
    idle(); wr(8'h01, 32'hFFFF_FFFF, 4'hF); step();
    check("misalign_wr_err", DW'(wr_err), 32'd1);
    idle(); wr(8'h20, 32'hFFFF_FFFF, 4'hF); step();
    check("idx_nregs_wr_err", DW'(wr_err), 32'd1);
    idle(); wr(8'h24, 32'hFFFF_FFFF, 4'hF); step();
    check("oob_wr_err", DW'(wr_err), 32'd1);

    // Random back-to-back traffic with a mid-stream reset.
    for (int c = 0; c < 100; c++) begin
      wr_valid = ($urandom_range(0, 3) != 0);
      wr_addr  = rand_addr();
      wr_data  = $urandom();
      wr_be    = NB'($urandom_range(0, 15));
      rd_valid = ($urandom_range(0, 3) != 0);
      rd_addr  = ($urandom_range(0, 2) == 0) ? wr_addr : rand_addr();
      for (int i = 0; i < NR; i++) begin
        hw_val[i*DW +: DW] = $urandom();
        hw_set[i*DW +: DW] = $urandom() & $urandom() & $urandom();
      end
      rst = (c == 50 || c == 51);
      step();
    end

    rst = 1'b0; idle(); step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
